// File: rtl/serial_frame_receiver_if.sv
// Signal bundle between a serial frame receiver and the logic around it:
// the serial line, the received-word handshake and the status flags.
interface serial_frame_receiver_if #(
    parameter int N = 4
);
    logic         SI;
    logic [N-1:0] Q;
    logic         valid;
    logic         ready;
    logic         busy;
    logic         parity_err;
    logic         frame_err;
    logic         overrun;

    // Line driver / word consumer side
    modport master (
        output SI,
        output ready,
        input  Q,
        input  valid,
        input  busy,
        input  parity_err,
        input  frame_err,
        input  overrun
    );

    // Receiver side
    modport slave (
        input  SI,
        input  ready,
        output Q,
        output valid,
        output busy,
        output parity_err,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit 0, N data bits LSB first, even parity,
// stop bit 1. Good words land in a single output register with a
// valid/ready handshake. Bad frames are dropped with a one-cycle error pulse.
// A good word that finds the register occupied sets a sticky overrun flag.
module serial_frame_receiver #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    serial_frame_receiver_if.slave sfr
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [N-1:0]  shreg;
    logic          par_bit;
    logic [N-1:0]  q_reg;
    logic          valid_reg;
    logic          parity_err_reg;
    logic          frame_err_reg;
    logic          overrun_reg;

    logic          take;
    logic          par_ok;
    logic          stop_good;
    logic          out_free;

    // Handshake and frame-check terms used by the output register.
    always_comb begin
        take      = valid_reg && sfr.ready;
        par_ok    = (par_bit == ^shreg);
        stop_good = (state == STOP) && sfr.SI && par_ok;
        out_free  = !valid_reg || sfr.ready;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. STOP always returns to IDLE, so a 0 stop bit is
    // never mistaken for the next start bit.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (!sfr.SI) state_nx = DATA;
            DATA:    if (cnt == CW'(N - 1)) state_nx = PARITY;
            PARITY:  state_nx = STOP;
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Bit counter, data shift register and captured parity bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!sfr.SI) cnt <= '0;
                end
                DATA: begin
                    // LSB arrives first, so after N shifts it sits in bit 0.
                    shreg <= {sfr.SI, shreg[N-1:1]};
                    cnt   <= cnt + CW'(1);
                end
                PARITY: begin
                    par_bit <= sfr.SI;
                end
                default: begin
                end
            endcase
        end
    end

    // Error pulses: a missing stop bit outranks a parity mismatch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            if (state == STOP) begin
                if (!sfr.SI) begin
                    frame_err_reg <= 1'b1;
                end else if (!par_ok) begin
                    parity_err_reg <= 1'b1;
                end
            end
        end
    end

    // Output register and handshake. A word consumed on the same edge a new
    // good word arrives is replaced directly and valid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg       <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (stop_good) begin
                if (out_free) begin
                    q_reg     <= shreg;
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (take) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign sfr.Q          = q_reg;
    assign sfr.valid      = valid_reg;
    assign sfr.busy       = (state != IDLE);
    assign sfr.parity_err = parity_err_reg;
    assign sfr.frame_err  = frame_err_reg;
    assign sfr.overrun    = overrun_reg;

endmodule
